snn_batch_sched: RTL

//  Batch scheduler for snn_core. Runs one classification per input-sample RAM

---
 rtl/snn_batch_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/snn_batch_sched.sv
`default_nettype none
// snn_batch_sched: runs one snn_core classification per sample bank, scores each
// digit against its label and reports per-sample results and batch totals.
module snn_batch_sched #(
  parameter int NUM_SAMPLES = 10,
  parameter int ADDR_WIDTH  = 10,
  parameter int TIMEOUT     = 1048576
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 go_i,
  input  logic                                 abort_i,
  input  logic [4*NUM_SAMPLES-1:0]             label_vec_i,
  output logic                                 core_start_o,
  input  logic                                 core_done_i,
  input  logic [3:0]                           core_digit_i,
  input  logic [ADDR_WIDTH-1:0]                core_addr_i,
  output logic                                 core_q_o,
  output logic [ADDR_WIDTH-1:0]                bank_addr_o,
  input  logic [NUM_SAMPLES-1:0]               bank_q_i,
  output logic                                 busy_o,
  output logic                                 result_valid_o,
  output logic [$clog2(NUM_SAMPLES)-1:0]       result_idx_o,
  output logic [3:0]                           result_digit_o,
  output logic                                 result_pass_o,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]     pass_cnt_o,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]     fail_cnt_o,
  output logic                                 batch_done_o
);

  localparam int IDX_W  = $clog2(NUM_SAMPLES);
  localparam int CNT_W  = $clog2(NUM_SAMPLES + 1);
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    sel_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                done_r_q;
  logic                busy_q;
  logic                core_start_q;
  logic                result_valid_q;
  logic [IDX_W-1:0]    result_idx_q;
  logic [3:0]          result_digit_q;
  logic                result_pass_q;
  logic [CNT_W-1:0]    pass_cnt_q;
  logic [CNT_W-1:0]    fail_cnt_q;
  logic                batch_done_q;

  logic [3:0]          labels [NUM_SAMPLES];
  logic                done_evt;
  logic                digit_hit;

  for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_label
    assign labels[gi] = label_vec_i[4*gi +: 4];
  end

  assign done_evt    = core_done_i & ~done_r_q;
  assign digit_hit   = done_evt & (core_digit_i == labels[sel_q]);
  assign bank_addr_o = core_addr_i;
  assign core_q_o    = bank_q_i[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      wdog_q         <= '0;
      done_r_q       <= 1'b0;
      busy_q         <= 1'b0;
      core_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_idx_q   <= '0;
      result_digit_q <= '0;
      result_pass_q  <= 1'b0;
      pass_cnt_q     <= '0;
      fail_cnt_q     <= '0;
      batch_done_q   <= 1'b0;
    end else begin
      done_r_q <= core_done_i;
      if (abort_i) begin
        state_q        <= S_IDLE;
        busy_q         <= 1'b0;
        core_start_q   <= 1'b0;
        result_valid_q <= 1'b0;
        batch_done_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (go_i) begin
              pass_cnt_q     <= '0;
              fail_cnt_q     <= '0;
              result_idx_q   <= '0;
              result_digit_q <= '0;
              result_pass_q  <= 1'b0;
              sel_q          <= '0;
              busy_q         <= 1'b1;
              core_start_q   <= 1'b1;
              state_q        <= S_START;
            end
          end
          S_START: begin
            // Masks a done level left over from the previous sample's run.
            done_r_q     <= 1'b1;
            core_start_q <= 1'b0;
            wdog_q       <= '0;
            state_q      <= S_WAIT;
          end
          S_WAIT: begin
            wdog_q <= wdog_q + WDOG_W'(1);
            if (done_evt || (wdog_q == WDOG_MAX)) begin
              result_valid_q <= 1'b1;
              result_idx_q   <= sel_q;
              result_digit_q <= done_evt ? core_digit_i : 4'hF;
              result_pass_q  <= digit_hit;
              if (digit_hit) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
              else           fail_cnt_q <= fail_cnt_q + CNT_W'(1);
              state_q        <= S_CHECK;
            end
          end
          S_CHECK: begin
            result_valid_q <= 1'b0;
            if (sel_q == LAST_IDX) begin
              batch_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              sel_q        <= sel_q + IDX_W'(1);
              core_start_q <= 1'b1;
              state_q      <= S_START;
            end
          end
          S_DONE: begin
            batch_done_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o         = busy_q;
  assign core_start_o   = core_start_q;
  assign result_valid_o = result_valid_q;
  assign result_idx_o   = result_idx_q;
  assign result_digit_o = result_digit_q;
  assign result_pass_o  = result_pass_q;
  assign pass_cnt_o     = pass_cnt_q;
  assign fail_cnt_o     = fail_cnt_q;
  assign batch_done_o   = batch_done_q;

endmodule
`default_nettype wire
